// File: rtl/sseg_scan_decoder.sv
// Receive-side monitor for a multiplexed 4-digit seven-segment bus.
// Samples each settled digit, decodes it to BCD and publishes whole frames.
module sseg_scan_decoder #(
    parameter int STABLE_CYCLES  = 1000,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic        M_CLOCK,
    input  logic        M_RESET_N,
    input  logic [3:0]  SSEGD_IN,
    input  logic [7:0]  SSEG_IN,
    output logic [15:0] DIGITS,
    output logic [3:0]  DP,
    output logic [3:0]  BLANK,
    output logic [3:0]  DIGIT_ERR,
    output logic        FRAME_VALID,
    output logic        TIMEOUT
);

    localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TOUT_MAX = TW'(TIMEOUT_CYCLES - 1);

    logic [3:0]      sel_s1, sel_s2;
    logic [7:0]      seg_s1, seg_s2;
    logic [SW-1:0]   stab_cnt;
    logic [TW-1:0]   tout_cnt;
    logic            armed;
    logic [3:0]      seen;
    logic [3:0][3:0] sh_dig;
    logic [3:0]      sh_dp, sh_blank, sh_err;

    logic            changed, sel_ok, sample, complete, tout;
    logic [1:0]      slot;
    logic [3:0]      dec_code;
    logic            dec_blank, dec_err;

    function automatic logic [5:0] decode(input logic [6:0] g);
        case (g)
            7'b1000000: decode = {4'd0, 2'b00};
            7'b1111001: decode = {4'd1, 2'b00};
            7'b0100100: decode = {4'd2, 2'b00};
            7'b0110000: decode = {4'd3, 2'b00};
            7'b0011001: decode = {4'd4, 2'b00};
            7'b0010010: decode = {4'd5, 2'b00};
            7'b0000010: decode = {4'd6, 2'b00};
            7'b1011000,
            7'b1111000: decode = {4'd7, 2'b00};
            7'b0000000: decode = {4'd8, 2'b00};
            7'b0010000: decode = {4'd9, 2'b00};
            7'b1111111: decode = {4'hF, 2'b10};
            default:    decode = {4'hF, 2'b01};
        endcase
    endfunction

    // Change is seen one stage early so the sample lands 2+STABLE+1 after settle
    always_comb begin
        changed = {sel_s1, seg_s1} != {sel_s2, seg_s2};
        sel_ok  = 1'b1;
        slot    = 2'd0;
        case (sel_s2)
            4'b1110: slot = 2'd3;
            4'b1101: slot = 2'd2;
            4'b1011: slot = 2'd1;
            4'b0111: slot = 2'd0;
            default: sel_ok = 1'b0;
        endcase
        {dec_code, dec_blank, dec_err} = decode(seg_s2[6:0]);
        sample   = armed && sel_ok && (stab_cnt == STAB_MAX);
        complete = (seen == 4'hF);
        tout     = !complete && (tout_cnt == TOUT_MAX);
    end

    always_ff @(posedge M_CLOCK) begin
        if (!M_RESET_N) begin
            sel_s1      <= '0;
            sel_s2      <= '0;
            seg_s1      <= '0;
            seg_s2      <= '0;
            stab_cnt    <= '0;
            tout_cnt    <= '0;
            armed       <= 1'b0;
            seen        <= '0;
            sh_dig      <= '0;
            sh_dp       <= '0;
            sh_blank    <= '0;
            sh_err      <= '0;
            DIGITS      <= '0;
            DP          <= '0;
            BLANK       <= '0;
            DIGIT_ERR   <= '0;
            FRAME_VALID <= 1'b0;
            TIMEOUT     <= 1'b0;
        end else begin
            sel_s1 <= SSEGD_IN;
            sel_s2 <= sel_s1;
            seg_s1 <= SSEG_IN;
            seg_s2 <= seg_s1;

            if (sample)
                armed <= 1'b0;
            if (changed) begin
                stab_cnt <= '0;
                armed    <= 1'b1;
            end else if (stab_cnt != STAB_MAX) begin
                stab_cnt <= stab_cnt + 1'b1;
            end

            FRAME_VALID <= complete;
            TIMEOUT     <= tout;

            if (complete) begin
                DIGITS    <= sh_dig;
                DP        <= sh_dp;
                BLANK     <= sh_blank;
                DIGIT_ERR <= sh_err;
            end

            if (complete || tout)
                tout_cnt <= '0;
            else
                tout_cnt <= tout_cnt + 1'b1;

            // A timeout discards the partial frame, including a same-cycle sample
            if (tout) begin
                seen     <= '0;
                sh_dig   <= '0;
                sh_dp    <= '0;
                sh_blank <= '0;
                sh_err   <= '0;
            end else begin
                seen <= (complete ? 4'h0 : seen)
                      | (sample ? (4'b0001 << slot) : 4'h0);
                if (sample) begin
                    sh_dig[slot]   <= dec_code;
                    sh_dp[slot]    <= ~seg_s2[7];
                    sh_blank[slot] <= dec_blank;
                    sh_err[slot]   <= dec_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Directed self-checking bench for sseg_scan_decoder.
// Uses STABLE_CYCLES=4 and TIMEOUT_CYCLES=64 to keep runs short.
module tb_sseg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  ssegd = 4'hF;
    logic [7:0]  sseg = 8'hFF;
    logic [15:0] digits;
    logic [3:0]  dp, blank, derr;
    logic        fv, tmo;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int fv_cnt = 0;
    int to_cnt = 0;
    int fv_time = 0;
    int to_time = 0;
    int t_d4 = 0;

    sseg_scan_decoder #(
        .STABLE_CYCLES (4),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .M_CLOCK    (clk),
        .M_RESET_N  (rst_n),
        .SSEGD_IN   (ssegd),
        .SSEG_IN    (sseg),
        .DIGITS     (digits),
        .DP         (dp),
        .BLANK      (blank),
        .DIGIT_ERR  (derr),
        .FRAME_VALID(fv),
        .TIMEOUT    (tmo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (fv) begin
            fv_cnt++;
            fv_time = cyc;
        end
        if (tmo) begin
            to_cnt++;
            to_time = cyc;
        end
    end

    task automatic drive(input logic [3:0] sel, input logic [7:0] seg,
                         input int n);
        ssegd = sel;
        sseg  = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan(input logic [7:0] g1, input logic [7:0] g2,
                        input logic [7:0] g3, input logic [7:0] g4);
        drive(4'b1110, g1, 10);
        drive(4'b1101, g2, 10);
        drive(4'b1011, g3, 10);
        t_d4 = cyc;
        drive(4'b0111, g4, 10);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ssegd = 4'hF;
        sseg  = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        fv_cnt = 0;
        to_cnt = 0;
    endtask

    task automatic chk_outs(input string nm, input logic [15:0] e_dig,
                            input logic [3:0] e_dp, input logic [3:0] e_bl,
                            input logic [3:0] e_er);
        checks++;
        if (digits !== e_dig) begin
            errors++;
            $display("FAIL %s digits: got %h expected %h", nm, digits, e_dig);
        end
        checks++;
        if (dp !== e_dp) begin
            errors++;
            $display("FAIL %s dp: got %b expected %b", nm, dp, e_dp);
        end
        checks++;
        if (blank !== e_bl) begin
            errors++;
            $display("FAIL %s blank: got %b expected %b", nm, blank, e_bl);
        end
        checks++;
        if (derr !== e_er) begin
            errors++;
            $display("FAIL %s digit_err: got %b expected %b", nm, derr, e_er);
        end
    endtask

    task automatic test_reset();
        do_reset();
        chk_outs("reset", 16'h0000, 4'h0, 4'h0, 4'h0);
        checks++;
        if (fv !== 1'b0 || tmo !== 1'b0) begin
            errors++;
            $display("FAIL reset pulses: got fv=%b to=%b expected 0 0", fv, tmo);
        end
    endtask

    task automatic test_basic();
        do_reset();
        scan(8'hF9, 8'hA4, 8'hC0, 8'hC0);
        drive(4'hF, 8'hFF, 5);
        checks++;
        if (fv_cnt !== 1) begin
            errors++;
            $display("FAIL basic fv_count: got %0d expected 1", fv_cnt);
        end
        checks++;
        if (fv_time - t_d4 !== 7) begin
            errors++;
            $display("FAIL basic latency: got %0d expected 7", fv_time - t_d4);
        end
        chk_outs("basic", 16'h1200, 4'h0, 4'h0, 4'h0);
    endtask

    task automatic test_dp();
        do_reset();
        scan(8'hF9, 8'hA4, 8'hC0, 8'h40);
        drive(4'hF, 8'hFF, 5);
        chk_outs("dp", 16'h1200, 4'b0001, 4'h0, 4'h0);
    endtask

    task automatic test_glyphs();
        do_reset();
        scan(8'hF8, 8'hD8, 8'h82, 8'h10);
        drive(4'hF, 8'hFF, 5);
        chk_outs("glyph_a", 16'h7769, 4'b0001, 4'h0, 4'h0);
        do_reset();
        scan(8'h99, 8'h92, 8'h00, 8'hB0);
        drive(4'hF, 8'hFF, 5);
        chk_outs("glyph_b", 16'h4583, 4'b0010, 4'h0, 4'h0);
    endtask

    task automatic test_short_dwell();
        do_reset();
        drive(4'b1110, 8'hF9, 10);
        drive(4'b1101, 8'hA4, 10);
        drive(4'b1011, 8'hC0, 2);
        drive(4'b0111, 8'hC0, 10);
        checks++;
        if (fv_cnt !== 0) begin
            errors++;
            $display("FAIL short_dwell no_frame: got %0d expected 0", fv_cnt);
        end
        scan(8'hF9, 8'hA4, 8'hC0, 8'hC0);
        checks++;
        if (fv_cnt !== 1) begin
            errors++;
            $display("FAIL short_dwell one_frame: got %0d expected 1", fv_cnt);
        end
        chk_outs("short_dwell", 16'h1200, 4'h0, 4'h0, 4'h0);
    endtask

    task automatic test_err_blank();
        do_reset();
        scan(8'hF9, 8'hAA, 8'hC0, 8'hC0);
        drive(4'hF, 8'hFF, 5);
        chk_outs("err", 16'h1F00, 4'h0, 4'h0, 4'b0100);
        do_reset();
        scan(8'hF9, 8'hFF, 8'hC0, 8'hC0);
        drive(4'hF, 8'hFF, 5);
        chk_outs("blank", 16'h1F00, 4'h0, 4'b0100, 4'h0);
    endtask

    task automatic test_timeout();
        do_reset();
        scan(8'hF9, 8'hA4, 8'hC0, 8'hC0);
        drive(4'b1110, 8'h99, 10);
        drive(4'b1101, 8'h92, 10);
        drive(4'b1011, 8'hB0, 10);
        ssegd = 4'hF;
        sseg  = 8'hFF;
        for (int i = 0; i < 120 && to_cnt == 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (to_cnt !== 1) begin
            errors++;
            $display("FAIL timeout pulse_count: got %0d expected 1", to_cnt);
        end
        checks++;
        if (to_time - fv_time !== 64) begin
            errors++;
            $display("FAIL timeout delay: got %0d expected 64",
                     to_time - fv_time);
        end
        checks++;
        if (fv_cnt !== 1) begin
            errors++;
            $display("FAIL timeout fv_count: got %0d expected 1", fv_cnt);
        end
        chk_outs("timeout_keep", 16'h1200, 4'h0, 4'h0, 4'h0);
    endtask

    task automatic test_mid_reset();
        drive(4'b1110, 8'hF9, 10);
        drive(4'b1101, 8'hA4, 10);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        fv_cnt = 0;
        chk_outs("mid_reset", 16'h0000, 4'h0, 4'h0, 4'h0);
        drive(4'b1011, 8'hC0, 10);
        drive(4'b0111, 8'hC0, 10);
        checks++;
        if (fv_cnt !== 0) begin
            errors++;
            $display("FAIL mid_reset partial: got %0d expected 0", fv_cnt);
        end
        scan(8'hF9, 8'hA4, 8'hC0, 8'hC0);
        checks++;
        if (fv_cnt !== 1) begin
            errors++;
            $display("FAIL mid_reset full: got %0d expected 1", fv_cnt);
        end
        chk_outs("mid_reset_frame", 16'h1200, 4'h0, 4'h0, 4'h0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dp();
        test_glyphs();
        test_short_dwell();
        test_err_blank();
        test_timeout();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
